// File: rtl/mem_pkg.sv
// Shared definitions for the Memory-stage data responder: access widths and
// the responder's state encoding.
package mem_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } MemState;

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane logic: merges store data into an existing word and
// extracts/extends load data from a word, both little-endian.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  width,
  input  logic [1:0]  byteOffset,
  input  logic        signExtend,
  output logic [31:0] mergedWord,
  output logic [31:0] loadData
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  assign byteVal = oldWord[{byteOffset, 3'b000} +: 8];
  assign halfVal = oldWord[{byteOffset[1], 4'b0000} +: 16];

  // Store merge: replace only the lanes covered by the access
  always_comb begin
    mergedWord = oldWord;
    case (width)
      MEM_WIDTH_BYTE: mergedWord[{byteOffset, 3'b000} +: 8] = wdata[7:0];
      MEM_WIDTH_HALF: mergedWord[{byteOffset[1], 4'b0000} +: 16] = wdata[15:0];
      MEM_WIDTH_WORD: mergedWord = wdata;
      default:        mergedWord = oldWord;
    endcase
  end

  // Load extraction: pick the addressed lane(s), then zero- or sign-extend
  always_comb begin
    loadData = oldWord;
    case (width)
      MEM_WIDTH_BYTE: loadData = {{24{signExtend & byteVal[7]}}, byteVal};
      MEM_WIDTH_HALF: loadData = {{16{signExtend & halfVal[15]}}, halfVal};
      default:        loadData = oldWord;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-stage load/store responder: one outstanding request, fixed latency,
// error flag for misaligned/out-of-range/reserved-width accesses.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_sign_extend,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  MemState            state;
  logic [CNT_W-1:0]   cnt;
  logic               busyQ;
  logic               respValidQ;
  logic               respErrorQ;

  logic               writeQ;
  logic [1:0]         widthQ;
  logic               signQ;
  logic [IDX_W+1:0]   addrQ;
  logic [31:0]        wdataQ;
  logic               errQ;

  logic               accept;
  logic               reqErr;
  logic [IDX_W-1:0]   wordIdx;
  logic [31:0]        readWord;
  logic [31:0]        mergedWord;
  logic [31:0]        loadData;

  logic [31:0]        mem [DEPTH_WORDS];

  assign req_ready = reset && ((state == IDLE) || (state == RESP));
  assign accept    = req_valid && req_ready;
  assign wordIdx   = addrQ[IDX_W+1:2];
  assign readWord  = mem[wordIdx];

  // Classify the incoming request so the error travels with it through the latency
  always_comb begin
    reqErr = 1'b0;
    case (req_width)
      MEM_WIDTH_BYTE: reqErr = 1'b0;
      MEM_WIDTH_HALF: reqErr = req_addr[0];
      MEM_WIDTH_WORD: reqErr = (req_addr[1:0] != 2'b00);
      default:        reqErr = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) reqErr = 1'b1;
  end

  mem_lane_unit laneUnit (
    .oldWord    (readWord),
    .wdata      (wdataQ),
    .width      (widthQ),
    .byteOffset (addrQ[1:0]),
    .signExtend (signQ),
    .mergedWord (mergedWord),
    .loadData   (loadData)
  );

  // Request FSM: latch on accept, count latency in WAIT, strobe the response in RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busyQ      <= 1'b0;
      respValidQ <= 1'b0;
      respErrorQ <= 1'b0;
      writeQ     <= 1'b0;
      widthQ     <= MEM_WIDTH_BYTE;
      signQ      <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      errQ       <= 1'b0;
    end else begin
      respValidQ <= 1'b0;
      respErrorQ <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            writeQ <= req_write;
            widthQ <= req_width;
            signQ  <= req_sign_extend;
            addrQ  <= req_addr[IDX_W+1:0];
            wdataQ <= req_wdata;
            errQ   <= reqErr;
            if (LATENCY == 1) begin
              state      <= RESP;
              busyQ      <= 1'b0;
              respValidQ <= 1'b1;
              respErrorQ <= reqErr;
            end else begin
              state <= WAIT;
              busyQ <= 1'b1;
              cnt   <= CNT_W'(LATENCY - 2);
            end
          end else begin
            state <= IDLE;
            busyQ <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            busyQ      <= 1'b0;
            respValidQ <= 1'b1;
            respErrorQ <= errQ;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busyQ <= 1'b0;
        end
      endcase
    end
  end

  // Array storage: cleared by reset, a good store commits at the edge ending its response cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if ((state == RESP) && writeQ && !errQ) begin
      mem[wordIdx] <= mergedWord;
    end
  end

  assign resp_valid = respValidQ;
  assign resp_error = respErrorQ;
  assign busy       = busyQ;
  assign resp_rdata = (respValidQ && !writeQ && !errQ) ? loadData : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: three instances with LATENCY 2, 1
// and 3, a reference memory model, and a response monitor popping expectations.
module tb_data_memory_responder;

  localparam int DEPTH = 16;
  localparam int LAT_TAB [3] = '{2, 1, 3};

  logic        clk = 1'b0;
  logic [2:0]  resetN = 3'b000;
  logic [2:0]  reqValid = 3'b000;
  logic [2:0]  reqWrite = 3'b000;
  logic [2:0]  reqSign = 3'b000;
  logic [2:0]  reqReady;
  logic [2:0]  respValid;
  logic [2:0]  respError;
  logic [2:0]  busy;
  logic [1:0]  reqWidth  [3];
  logic [31:0] reqAddr   [3];
  logic [31:0] reqWdata  [3];
  logic [31:0] respRdata [3];

  typedef struct {
    int          inst;
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } ExpResp;

  ExpResp      expQ[$];
  logic [31:0] modelMem [3][DEPTH];
  int          cycle = 0;
  int          passCount = 0;
  int          checkCount = 0;
  int          busyCount [3];
  int          readyLow [3];

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < 3; g++) begin : gDut
    data_memory_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     ((g == 0) ? 2 : ((g == 1) ? 1 : 3))
    ) dut (
      .clk             (clk),
      .reset           (resetN[g]),
      .req_valid       (reqValid[g]),
      .req_ready       (reqReady[g]),
      .req_write       (reqWrite[g]),
      .req_width       (reqWidth[g]),
      .req_sign_extend (reqSign[g]),
      .req_addr        (reqAddr[g]),
      .req_wdata       (reqWdata[g]),
      .resp_valid      (respValid[g]),
      .resp_rdata      (respRdata[g]),
      .resp_error      (respError[g]),
      .busy            (busy[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Reference model of one access: error rules, lane merge and extension
  function automatic void modelAccess(input int i, input bit write, input logic [1:0] width,
                                      input bit sign, input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic err);
    int nBytes;
    int off;
    int w;
    logic [31:0] val;
    err = (width == 2'd3) || (width == 2'd1 && addr[0]) ||
          (width == 2'd2 && addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    rdata = 32'd0;
    if (!err) begin
      nBytes = 1 << width;
      off = int'(addr[1:0]);
      w = int'(addr[31:2]);
      if (write) begin
        for (int b = 0; b < nBytes; b++) modelMem[i][w][8*(off+b) +: 8] = wdata[8*b +: 8];
      end else begin
        val = 32'd0;
        for (int b = 0; b < nBytes; b++) val[8*b +: 8] = modelMem[i][w][8*(off+b) +: 8];
        if (sign && nBytes < 4 && val[8*nBytes-1])
          for (int k = 8*nBytes; k < 32; k++) val[k] = 1'b1;
        rdata = val;
      end
    end
  endfunction

  // Response monitor: pops the scoreboard on every strobe and flags late/missing responses
  always @(negedge clk) begin
    ExpResp e;
    for (int i = 0; i < 3; i++) begin
      if (busy[i] === 1'b1) busyCount[i]++;
      if (resetN[i] && reqReady[i] !== 1'b1) readyLow[i]++;
      if (respValid[i] === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResp", {31'd0, respValid[i]}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.tag, "/inst"}, i, e.inst);
          checkOutput({e.tag, "/cycle"}, cycle, e.due);
          checkOutput({e.tag, "/rdata"}, respRdata[i], e.rdata);
          checkOutput({e.tag, "/error"}, {31'd0, respError[i]}, {31'd0, e.err});
        end
      end
    end
    if (expQ.size() > 0 && expQ[0].due < cycle) begin
      checkOutput({expQ[0].tag, "/missingResp"}, cycle, expQ[0].due);
      void'(expQ.pop_front());
    end
  end

  // Drive one request (called just after a rising edge); returns just after its accept edge
  task automatic applyStimulus(input int i, input string tag, input bit write, input logic [1:0] width,
                               input bit sign, input logic [31:0] addr, input logic [31:0] wdata,
                               input bit expectResp);
    ExpResp e;
    int waited;
    reqValid[i] = 1'b1;
    reqWrite[i] = write;
    reqWidth[i] = width;
    reqSign[i]  = sign;
    reqAddr[i]  = addr;
    reqWdata[i] = wdata;
    @(negedge clk);
    waited = 0;
    while (reqReady[i] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (reqReady[i] !== 1'b1) begin
      checkOutput({tag, "/readyTimeout"}, {31'd0, reqReady[i]}, 32'd1);
      @(posedge clk);
      #1 reqValid[i] = 1'b0;
      return;
    end
    if (expectResp) begin
      e.inst = i;
      e.tag  = tag;
      e.due  = cycle + LAT_TAB[i];
      modelAccess(i, write, width, sign, addr, wdata, e.rdata, e.err);
      expQ.push_back(e);
    end
    @(posedge clk);
    #1 reqValid[i] = 1'b0;
  endtask

  task automatic resetInst(input int i);
    resetN[i] = 1'b0;
    for (int w = 0; w < DEPTH; w++) modelMem[i][w] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("resetReady", {31'd0, reqReady[i]}, 32'd0);
    checkOutput("resetRespValid", {31'd0, respValid[i]}, 32'd0);
    checkOutput("resetRdata", respRdata[i], 32'd0);
    checkOutput("resetError", {31'd0, respError[i]}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy[i]}, 32'd0);
    @(posedge clk);
    #1 resetN[i] = 1'b1;
  endtask

  task automatic waitDrain();
    int waited = 0;
    while (expQ.size() > 0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (expQ.size() > 0) begin
      checkOutput("drainTimeout", expQ.size(), 32'd0);
      expQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      reqWidth[i] = 2'd0;
      reqAddr[i] = 32'd0;
      reqWdata[i] = 32'd0;
      busyCount[i] = 0;
      readyLow[i] = 0;
    end
    @(posedge clk);
    #1;
    resetInst(0);
    resetInst(1);
    resetInst(2);

    // LATENCY=2: word store/load and busy duration
    busyCount[0] = 0;
    applyStimulus(0, "sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
    applyStimulus(0, "lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);
    waitDrain();
    checkOutput("busyCycles", busyCount[0], 32'd2);

    // Byte and half lanes with sign/zero extension
    applyStimulus(0, "sb13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 1'b1);
    applyStimulus(0, "lb13", 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b1);
    applyStimulus(0, "lbu13", 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 1'b1);
    applyStimulus(0, "lw10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);
    applyStimulus(0, "sh10", 1'b1, 2'd1, 1'b0, 32'h10, 32'h1234, 1'b1);
    applyStimulus(0, "lw10c", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);
    applyStimulus(0, "lhs12", 1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 1'b1);

    // Alignment, width and range errors
    applyStimulus(0, "lwMisal", 1'b0, 2'd2, 1'b0, 32'h12, 32'd0, 1'b1);
    applyStimulus(0, "shMisal", 1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF, 1'b1);
    applyStimulus(0, "lw10d", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);
    applyStimulus(0, "width3", 1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 1'b1);
    applyStimulus(0, "swRange", 1'b1, 2'd2, 1'b0, DEPTH * 4, 32'hA5A5A5A5, 1'b1);
    for (int w = 0; w < DEPTH; w++)
      applyStimulus(0, "scan", 1'b0, 2'd2, 1'b0, w * 4, 32'd0, 1'b1);
    waitDrain();

    // LATENCY=1: back-to-back read-after-write, never busy, always ready
    busyCount[1] = 0;
    readyLow[1] = 0;
    applyStimulus(1, "l1sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'd5, 1'b1);
    applyStimulus(1, "l1lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b1);
    applyStimulus(1, "l1sb21", 1'b1, 2'd0, 1'b0, 32'h21, 32'hC3, 1'b1);
    applyStimulus(1, "l1lb21", 1'b0, 2'd0, 1'b1, 32'h21, 32'd0, 1'b1);
    waitDrain();
    checkOutput("l1Busy", busyCount[1], 32'd0);
    checkOutput("l1ReadyLow", readyLow[1], 32'd0);

    // LATENCY=3: reset one cycle after accept drops the store
    applyStimulus(2, "l3sw34", 1'b1, 2'd2, 1'b0, 32'h34, 32'd9, 1'b1);
    applyStimulus(2, "l3lw34", 1'b0, 2'd2, 1'b0, 32'h34, 32'd0, 1'b1);
    waitDrain();
    applyStimulus(2, "l3sw30", 1'b1, 2'd2, 1'b0, 32'h30, 32'd7, 1'b0);
    resetN[2] = 1'b0;
    for (int w = 0; w < DEPTH; w++) modelMem[2][w] = 32'd0;
    @(posedge clk);
    #1 resetN[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("l3NoResp", {31'd0, respValid[2]}, 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(2, "l3lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 1'b1);
    waitDrain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the CPU's Memory-stage load/store requests. It accepts one request at a time over a valid/ready handshake and responds after a fixed, parameterised latency. Stores are merged into byte lanes and loads are extracted with sign or zero extension. Its `busy` output feeds the pipeline's stall-level logic as the Memory-stage wait source, and a response carries an error flag for misaligned or out-of-range accesses.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array.
- `LATENCY`, default 2: cycles from request accept to response. Legal values are ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low: asserted when 0, sampled on the rising edge of `clk`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_width`  in  2  access width: byte=0, half=1, word=2; 3 is reserved.
- `req_sign_extend`  in  1  sign-extend load result (loads only).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response strobe; no backpressure.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_error`  out  1  request was misaligned, out of range, or had a reserved width.
- `busy`  out  1  request outstanding and response not yet issued.

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, counting latency.
  - RESP: response cycle.
- Accept condition: `req_valid && req_ready`. `req_ready` = (state is IDLE or RESP) and `reset` deasserted.
- On accept, latch all request fields and evaluate the error condition. A request is an error when any of these holds:
  - width is 3;
  - half access with `addr[0]`≠0;
  - word access with `addr[1:0]`≠0;
  - `addr[31:2]` ≥ `DEPTH_WORDS`.
- Transitions:
  - Accept with LATENCY=1: go to RESP.
  - Accept with LATENCY>1: go to WAIT, loading the counter with LATENCY−2; WAIT decrements the counter and moves to RESP at 0.
  - RESP with a new accept: handled as an accept from IDLE.
  - RESP with no accept: go to IDLE.
- Errors take the same latency as good requests. They perform no write and return `rdata`=0.
- Store: byte lanes are little-endian.
  - Byte: lane `addr[1:0]` is written with `wdata[7:0]`.
  - Half: lanes {2·`addr[1]`+1, 2·`addr[1]`} are written with `wdata[15:0]`.
  - Word: all four lanes are written.
  - The write commits on the rising edge that ends the RESP cycle.
- Load: the word is read from the array during RESP. The addressed byte or half is extracted, then zero- or sign-extended per the latched `req_sign_extend`. Word loads ignore `req_sign_extend`.
- `busy` = (state == WAIT).

## Timing
- Accept at cycle T gives `resp_valid` high in cycle T+LATENCY only.
- Maximum throughput: one request per LATENCY cycles, with back-to-back accept allowed in the RESP cycle.
- Read-after-write: a load accepted in the store's RESP cycle observes the new data.
- Reset values: state IDLE; `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `busy`=0, `req_ready`=0 while reset is asserted; all array words 0.
- Reset during WAIT or RESP drops the pending request:
  - no `resp_valid`;
  - no write commits, including when reset coincides with the RESP edge.
- `req_*` inputs are ignored when not accepted.

## Structure
- Shared package `mem_pkg` holds:
  - width constants `MEM_WIDTH_BYTE`=0, `MEM_WIDTH_HALF`=1, `MEM_WIDTH_WORD`=2;
  - the state encoding IDLE/WAIT/RESP.
- Sub-module `mem_lane_unit` is combinational. It performs:
  - store lane merge: old word + wdata + width + `addr[1:0]` → new word;
  - load extraction and extension: word + width + `addr[1:0]` + sign flag → result.
- Top level holds the FSM, the latency counter, the request latch, error detection and the array.

## Test plan
- LATENCY=2. Reset, then sw 0xDEADBEEF to 0x10, then lw 0x10 → for each request, `resp_valid` at accept+2. The load returns `rdata`=0xDEADBEEF, `error`=0, and `busy` is high for exactly 1 cycle per request.
- After the above, sb 0x80 at 0x13, then:
  - lb 0x13 → 0xFFFFFF80;
  - lbu 0x13 → 0x00000080;
  - lw 0x10 → 0x80ADBEEF.
  - Then sh 0x1234 at 0x10 and lw 0x10 → 0x80AD1234.
- Alignment and width errors:
  - lw 0x12 → `error`=1, `rdata`=0;
  - sh to 0x11 → `error`=1, and a later lw 0x10 is unchanged;
  - width=3 → `error`=1.
- sw to address `DEPTH_WORDS`·4 → `error`=1 at accept+LATENCY, and no word is modified (array scan).
- LATENCY=1:
  - sw 0x20=5 and lw 0x20 on consecutive cycles → lw returns 5;
  - `req_ready` stays 1 and `busy` stays 0 throughout.
- Reset mid-operation with LATENCY=3: accept sw 0x30=7, then assert reset at accept+1 for one cycle → no `resp_valid`, and a subsequent lw 0x30 returns 0.
